// File: rtl/line_packer_pkg.sv
// Shared types and helpers for the line packer.
// Pure declarations: no latency, no flow control.
// Word budget per line is header + packed pixel pairs, padded to a 4-word beat.
package line_packer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_FLUSH,
        ST_PAD
    } state_t;

    localparam logic [15:0] HDR_MAGIC_DEF = 16'hA55A;
    localparam logic [31:0] PAD_WORD      = 32'h0;

    // roundup4(1 + ceil(n/2)), in 17 bits so n = 16'hFFFF cannot wrap
    function automatic logic [16:0] words_needed(input logic [15:0] n);
        logic [16:0] t;
        t = 17'd1 + (({1'b0, n} + 17'd1) >> 1);
        return (t + 17'd3) & ~17'd3;
    endfunction

endpackage

// File: rtl/line_packer.sv
// Packs 16-bit pixels two per 32-bit word, with a header and 4-word pad per line.
// Latency: header 1 cycle after sync, data word 1 cycle after its odd pixel.
// No backpressure: a line is admitted only if the FIFO can hold it whole, else dropped.
module line_packer
    import line_packer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4096,
    parameter int          MARGIN     = 16,
    parameter logic [15:0] HDR_MAGIC  = HDR_MAGIC_DEF
) (
    input  logic        CLK,
    input  logic        SRST,
    input  logic        ENABLE,
    input  logic [15:0] LINE_PIXELS,
    input  logic        LINE_SYNC,
    input  logic [15:0] PIX_DATA,
    input  logic        PIX_DV,
    input  logic [11:0] WR_CNT,
    output logic [31:0] FIFO_DIN,
    output logic        FIFO_DIN_DV,
    output logic [15:0] LINE_CNT,
    output logic [15:0] DROP_CNT,
    output logic [15:0] TRUNC_CNT,
    output logic        BUSY
);

    state_t      state, state_nxt, end_state;
    logic [15:0] n_lat, n_nxt;
    logic [15:0] pix_cnt, pix_nxt;
    logic [15:0] part, part_nxt;
    logic [1:0]  wcnt, wcnt_nxt, wcnt_inc;
    logic [31:0] din_nxt;
    logic        dv_nxt;
    logic [15:0] line_nxt, drop_nxt, trunc_nxt;
    logic [15:0] drop_sat, trunc_sat;
    logic [17:0] demand;
    logic        admit, done;

    assign demand    = {6'b0, WR_CNT} + {1'b0, words_needed(LINE_PIXELS)} + 18'(MARGIN);
    assign admit     = demand <= 18'(FIFO_DEPTH);
    assign done      = pix_cnt == n_lat;
    assign wcnt_inc  = wcnt + 2'd1;
    assign drop_sat  = (DROP_CNT == 16'hFFFF) ? DROP_CNT : DROP_CNT + 16'd1;
    assign trunc_sat = (TRUNC_CNT == 16'hFFFF) ? TRUNC_CNT : TRUNC_CNT + 16'd1;

    // An odd pixel count leaves half a word pending; otherwise pad unless already aligned
    assign end_state = pix_cnt[0] ? ST_FLUSH : ((wcnt == 2'd0) ? ST_IDLE : ST_PAD);

    always_comb begin
        state_nxt = state;
        n_nxt     = n_lat;
        pix_nxt   = pix_cnt;
        part_nxt  = part;
        wcnt_nxt  = wcnt;
        din_nxt   = PAD_WORD;
        dv_nxt    = 1'b0;
        line_nxt  = LINE_CNT;
        drop_nxt  = DROP_CNT;
        trunc_nxt = TRUNC_CNT;

        case (state)
            ST_IDLE: begin
                if (LINE_SYNC && ENABLE) begin
                    if (admit) begin
                        state_nxt = ST_HDR;
                        n_nxt     = LINE_PIXELS;
                        din_nxt   = {HDR_MAGIC, LINE_CNT};
                        dv_nxt    = 1'b1;
                        line_nxt  = LINE_CNT + 16'd1;
                        wcnt_nxt  = 2'd1;
                        pix_nxt   = 16'd0;
                        part_nxt  = 16'd0;
                        if (PIX_DV && LINE_PIXELS != 16'd0) begin
                            part_nxt = PIX_DATA;
                            pix_nxt  = 16'd1;
                        end
                    end else begin
                        drop_nxt = drop_sat;
                    end
                end
            end
            ST_HDR, ST_DATA: begin
                if (LINE_SYNC)
                    drop_nxt = drop_sat;
                if (state == ST_DATA && LINE_SYNC && !done) begin
                    trunc_nxt = trunc_sat;
                    state_nxt = end_state;
                end else if (done) begin
                    state_nxt = end_state;
                end else begin
                    state_nxt = ST_DATA;
                    if (PIX_DV) begin
                        pix_nxt = pix_cnt + 16'd1;
                        if (!pix_cnt[0]) begin
                            part_nxt = PIX_DATA;
                        end else begin
                            din_nxt  = {PIX_DATA, part};
                            dv_nxt   = 1'b1;
                            wcnt_nxt = wcnt_inc;
                        end
                    end
                end
            end
            ST_FLUSH, ST_PAD: begin
                if (LINE_SYNC)
                    drop_nxt = drop_sat;
                din_nxt   = (state == ST_FLUSH) ? {16'h0, part} : PAD_WORD;
                dv_nxt    = 1'b1;
                wcnt_nxt  = wcnt_inc;
                state_nxt = (wcnt_inc == 2'd0) ? ST_IDLE : ST_PAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state       <= ST_IDLE;
            n_lat       <= 16'd0;
            pix_cnt     <= 16'd0;
            part        <= 16'd0;
            wcnt        <= 2'd0;
            FIFO_DIN    <= 32'd0;
            FIFO_DIN_DV <= 1'b0;
            LINE_CNT    <= 16'd0;
            DROP_CNT    <= 16'd0;
            TRUNC_CNT   <= 16'd0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_nxt;
            n_lat       <= n_nxt;
            pix_cnt     <= pix_nxt;
            part        <= part_nxt;
            wcnt        <= wcnt_nxt;
            FIFO_DIN    <= din_nxt;
            FIFO_DIN_DV <= dv_nxt;
            LINE_CNT    <= line_nxt;
            DROP_CNT    <= drop_nxt;
            TRUNC_CNT   <= trunc_nxt;
            BUSY        <= state_nxt != ST_IDLE;
        end
    end

endmodule

// File: tb/tb_line_packer.sv
// Directed bench for line_packer: packing, padding, admission, truncation, reset.
module tb_line_packer;

    logic        CLK = 1'b0;
    logic        SRST;
    logic        ENABLE;
    logic [15:0] LINE_PIXELS;
    logic        LINE_SYNC;
    logic [15:0] PIX_DATA;
    logic        PIX_DV;
    logic [11:0] WR_CNT;
    logic [31:0] FIFO_DIN;
    logic        FIFO_DIN_DV;
    logic [15:0] LINE_CNT;
    logic [15:0] DROP_CNT;
    logic [15:0] TRUNC_CNT;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    logic [31:0] wq[$];
    logic [31:0] exp_w[$];

    line_packer dut (
        .CLK(CLK), .SRST(SRST), .ENABLE(ENABLE), .LINE_PIXELS(LINE_PIXELS),
        .LINE_SYNC(LINE_SYNC), .PIX_DATA(PIX_DATA), .PIX_DV(PIX_DV), .WR_CNT(WR_CNT),
        .FIFO_DIN(FIFO_DIN), .FIFO_DIN_DV(FIFO_DIN_DV), .LINE_CNT(LINE_CNT),
        .DROP_CNT(DROP_CNT), .TRUNC_CNT(TRUNC_CNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK)
        if (FIFO_DIN_DV === 1'b1) wq.push_back(FIFO_DIN);

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 64 && BUSY; k++) tick();
        checks++;
        if (BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout: BUSY=%b after 64 cycles, want 0", BUSY);
        end
        tick();
        tick();
    endtask

    // Sync carries pixel 0; trunc_at>0 replaces pixel trunc_at with a new LINE_SYNC
    task automatic send_line(input logic [15:0] n, input logic [15:0] base,
                             input int npix, input int trunc_at);
        wq.delete();
        LINE_PIXELS = n;
        LINE_SYNC   = 1'b1;
        PIX_DV      = (npix > 0);
        PIX_DATA    = base;
        tick();
        LINE_SYNC = 1'b0;
        for (int i = 1; i < npix; i++) begin
            if (trunc_at == i) begin
                LINE_SYNC = 1'b1;
                PIX_DV    = 1'b0;
                tick();
                LINE_SYNC = 1'b0;
                break;
            end
            PIX_DV   = 1'b1;
            PIX_DATA = base + 16'(i);
            tick();
        end
        PIX_DV    = 1'b0;
        LINE_SYNC = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        SRST = 1'b1; ENABLE = 1'b1; LINE_PIXELS = 16'd0; LINE_SYNC = 1'b0;
        PIX_DATA = 16'd0; PIX_DV = 1'b0; WR_CNT = 12'd0;
        tick(); tick(); tick();
        checks++; if (FIFO_DIN_DV !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", FIFO_DIN_DV); end
        checks++; if (FIFO_DIN !== 32'h0) begin errors++; $display("FAIL reset_din: got %h want 0", FIFO_DIN); end
        checks++; if (LINE_CNT !== 16'h0) begin errors++; $display("FAIL reset_line_cnt: got %h want 0", LINE_CNT); end
        checks++; if (DROP_CNT !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt: got %h want 0", DROP_CNT); end
        checks++; if (TRUNC_CNT !== 16'h0) begin errors++; $display("FAIL reset_trunc_cnt: got %h want 0", TRUNC_CNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        SRST = 1'b0;
        tick();
    endtask

    task automatic test_even_line();
        send_line(16'd4, 16'd1, 4, 0);
        exp_w = '{32'hA55A0000, 32'h00020001, 32'h00040003, 32'h00000000};
        checks++; if (wq.size() != exp_w.size()) begin errors++; $display("FAIL even_count: got %0d want %0d", wq.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL even_word%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, exp_w[i]);
            end
        end
        checks++; if (LINE_CNT !== 16'd1) begin errors++; $display("FAIL even_line_cnt: got %0d want 1", LINE_CNT); end
    endtask

    task automatic test_odd_line();
        send_line(16'd5, 16'h10, 5, 0);
        exp_w = '{32'hA55A0001, 32'h00110010, 32'h00130012, 32'h00000014};
        checks++; if (wq.size() != exp_w.size()) begin errors++; $display("FAIL odd_count: got %0d want %0d", wq.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL odd_word%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, exp_w[i]);
            end
        end
        checks++; if (LINE_CNT !== 16'd2) begin errors++; $display("FAIL odd_line_cnt: got %0d want 2", LINE_CNT); end
    endtask

    task automatic test_empty_line();
        int busy_cycles;
        wq.delete();
        LINE_PIXELS = 16'd0;
        LINE_SYNC   = 1'b1;
        tick();
        LINE_SYNC = 1'b0;
        busy_cycles = 0;
        while (BUSY && busy_cycles < 20) begin
            busy_cycles++;
            tick();
        end
        tick();
        tick();
        checks++; if (busy_cycles != 4) begin errors++; $display("FAIL empty_busy_cycles: got %0d want 4", busy_cycles); end
        exp_w = '{32'hA55A0002, 32'h0, 32'h0, 32'h0};
        checks++; if (wq.size() != exp_w.size()) begin errors++; $display("FAIL empty_count: got %0d want %0d", wq.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL empty_word%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, exp_w[i]);
            end
        end
    endtask

    // need(8)=8: 4073+8+16=4097 is one word too many, 4072 fits exactly
    task automatic test_admission();
        WR_CNT = 12'd4073;
        send_line(16'd8, 16'h50, 8, 0);
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL drop_writes: got %0d want 0", wq.size()); end
        checks++; if (DROP_CNT !== 16'd1) begin errors++; $display("FAIL drop_cnt: got %0d want 1", DROP_CNT); end
        checks++; if (LINE_CNT !== 16'd3) begin errors++; $display("FAIL drop_line_cnt: got %0d want 3", LINE_CNT); end
        WR_CNT = 12'd4072;
        send_line(16'd8, 16'h50, 8, 0);
        exp_w = '{32'hA55A0003, 32'h00510050, 32'h00530052, 32'h00550054,
                  32'h00570056, 32'h0, 32'h0, 32'h0};
        checks++; if (wq.size() != exp_w.size()) begin errors++; $display("FAIL accept_count: got %0d want %0d", wq.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL accept_word%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, exp_w[i]);
            end
        end
        checks++; if (LINE_CNT !== 16'd4) begin errors++; $display("FAIL accept_line_cnt: got %0d want 4", LINE_CNT); end
        WR_CNT = 12'd0;
    endtask

    task automatic test_truncate();
        send_line(16'd10, 16'h20, 10, 3);
        exp_w = '{32'hA55A0004, 32'h00210020, 32'h00000022, 32'h0};
        checks++; if (wq.size() != exp_w.size()) begin errors++; $display("FAIL trunc_count: got %0d want %0d", wq.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL trunc_word%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, exp_w[i]);
            end
        end
        checks++; if (TRUNC_CNT !== 16'd1) begin errors++; $display("FAIL trunc_cnt: got %0d want 1", TRUNC_CNT); end
        checks++; if (DROP_CNT !== 16'd2) begin errors++; $display("FAIL trunc_drop_cnt: got %0d want 2", DROP_CNT); end
        checks++; if (LINE_CNT !== 16'd5) begin errors++; $display("FAIL trunc_line_cnt: got %0d want 5", LINE_CNT); end
    endtask

    task automatic test_enable_low();
        ENABLE = 1'b0;
        send_line(16'd4, 16'h60, 4, 0);
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL disabled_writes: got %0d want 0", wq.size()); end
        checks++; if (DROP_CNT !== 16'd2) begin errors++; $display("FAIL disabled_drop_cnt: got %0d want 2", DROP_CNT); end
        checks++; if (LINE_CNT !== 16'd5) begin errors++; $display("FAIL disabled_line_cnt: got %0d want 5", LINE_CNT); end
        ENABLE = 1'b1;
    endtask

    task automatic test_reset_mid_line();
        LINE_PIXELS = 16'd10;
        LINE_SYNC   = 1'b1;
        PIX_DV      = 1'b1;
        PIX_DATA    = 16'h30;
        tick();
        LINE_SYNC = 1'b0;
        for (int i = 1; i < 4; i++) begin
            PIX_DATA = 16'h30 + 16'(i);
            tick();
        end
        PIX_DV = 1'b0;
        SRST   = 1'b1;
        tick();
        checks++; if (FIFO_DIN_DV !== 1'b0) begin errors++; $display("FAIL midrst_dv: got %b want 0", FIFO_DIN_DV); end
        checks++; if (LINE_CNT !== 16'd0) begin errors++; $display("FAIL midrst_line_cnt: got %0d want 0", LINE_CNT); end
        checks++; if (DROP_CNT !== 16'd0) begin errors++; $display("FAIL midrst_drop_cnt: got %0d want 0", DROP_CNT); end
        checks++; if (TRUNC_CNT !== 16'd0) begin errors++; $display("FAIL midrst_trunc_cnt: got %0d want 0", TRUNC_CNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", BUSY); end
        SRST = 1'b0;
        tick();
        send_line(16'd2, 16'h40, 2, 0);
        exp_w = '{32'hA55A0000, 32'h00410040, 32'h0, 32'h0};
        checks++; if (wq.size() != exp_w.size()) begin errors++; $display("FAIL postrst_count: got %0d want %0d", wq.size(), exp_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL postrst_word%0d: got %h want %h", i, (i < wq.size()) ? wq[i] : 32'hx, exp_w[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_line();
        test_odd_line();
        test_empty_line();
        test_admission();
        test_truncate();
        test_enable_low();
        test_reset_mid_line();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
